// File: rtl/calc1_responder.sv
// calc1 behavioural responder: four two-cycle request ports sharing one round-robin ALU.
// Optional macro CALC1_PROTO_CHECK_EN adds the sticky per-port proto_err output.
module calc1_responder #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp4,
  output logic [0:31] out_data4
`ifdef CALC1_PROTO_CHECK_EN
  ,
  output logic [1:4]  proto_err
`endif
);

  typedef enum logic [1:0] {StIdle, StOp2, StWait, StExec} port_st_e;

  localparam logic [3:0] CntInit = 4'(ALU_LAT - 1);

  logic [3:0]  cmd_in  [4];
  logic [31:0] data_in [4];

  port_st_e    st_q    [4];
  port_st_e    st_d    [4];
  logic [3:0]  cmd_q   [4];
  logic [3:0]  cmd_d   [4];
  logic [31:0] op1_q   [4];
  logic [31:0] op1_d   [4];
  logic [31:0] op2_q   [4];
  logic [31:0] op2_d   [4];
  logic [1:0]  resp_q  [4];
  logic [1:0]  resp_d  [4];
  logic [31:0] rdata_q [4];
  logic [31:0] rdata_d [4];

  logic       alu_busy_q, alu_busy_d;
  logic [3:0] alu_cnt_q, alu_cnt_d;
  logic [1:0] alu_port_q, alu_port_d;
  logic [1:0] rr_q, rr_d;

  logic        alu_done, alu_free;
  logic        grant_vld;
  logic [1:0]  grant_idx, cand;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_a, alu_b;
  logic [32:0] sum;
  logic [1:0]  res_code;
  logic [31:0] res_data;

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = rdata_q[0];
  assign out_data2 = rdata_q[1];
  assign out_data3 = rdata_q[2];
  assign out_data4 = rdata_q[3];

  // The ALU frees up on the edge it writes a response, allowing back-to-back issue.
  assign alu_done = alu_busy_q && (alu_cnt_q == 4'd0);
  assign alu_free = !alu_busy_q || alu_done;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_q;
    cand      = rr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_q + 2'(k);
      if (alu_free && !grant_vld && (st_q[cand] == StWait)) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign alu_cmd = cmd_q[alu_port_q];
  assign alu_a   = op1_q[alu_port_q];
  assign alu_b   = op2_q[alu_port_q];
  assign sum     = {1'b0, alu_a} + {1'b0, alu_b};

  always_comb begin
    res_code = 2'd3;
    res_data = '0;
    case (alu_cmd)
      4'd1: begin
        if (sum[32]) begin
          res_code = 2'd2;
        end else begin
          res_code = 2'd1;
          res_data = sum[31:0];
        end
      end
      4'd2: begin
        if (alu_a < alu_b) begin
          res_code = 2'd2;
        end else begin
          res_code = 2'd1;
          res_data = alu_a - alu_b;
        end
      end
      4'd5: begin
        res_code = 2'd1;
        res_data = alu_a << alu_b[4:0];
      end
      4'd6: begin
        res_code = 2'd1;
        res_data = alu_a >> alu_b[4:0];
      end
      default: begin
        res_code = 2'd3;
        res_data = '0;
      end
    endcase
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      st_d[n]    = st_q[n];
      cmd_d[n]   = cmd_q[n];
      op1_d[n]   = op1_q[n];
      op2_d[n]   = op2_q[n];
      resp_d[n]  = '0;
      rdata_d[n] = '0;
      unique case (st_q[n])
        StIdle: begin
          if (cmd_in[n] != 4'd0) begin
            cmd_d[n] = cmd_in[n];
            op1_d[n] = data_in[n];
            st_d[n]  = StOp2;
          end
        end
        StOp2: begin
          op2_d[n] = data_in[n];
          st_d[n]  = StWait;
        end
        StWait: begin
          if (grant_vld && (grant_idx == 2'(n))) st_d[n] = StExec;
        end
        StExec: begin
          if (alu_done && (alu_port_q == 2'(n))) begin
            st_d[n]    = StIdle;
            resp_d[n]  = res_code;
            rdata_d[n] = res_data;
          end
        end
        default: st_d[n] = StIdle;
      endcase
    end
  end

  always_comb begin
    alu_busy_d = alu_busy_q;
    alu_cnt_d  = alu_cnt_q;
    alu_port_d = alu_port_q;
    rr_d       = rr_q;
    if (grant_vld) begin
      alu_busy_d = 1'b1;
      alu_cnt_d  = CntInit;
      alu_port_d = grant_idx;
      rr_d       = grant_idx;
    end else if (alu_done) begin
      alu_busy_d = 1'b0;
    end else if (alu_busy_q) begin
      alu_cnt_d = alu_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        st_q[n]    <= StIdle;
        cmd_q[n]   <= '0;
        op1_q[n]   <= '0;
        op2_q[n]   <= '0;
        resp_q[n]  <= '0;
        rdata_q[n] <= '0;
      end
      alu_busy_q <= 1'b0;
      alu_cnt_q  <= '0;
      alu_port_q <= '0;
      rr_q       <= 2'd3;  // port 4, so port 1 wins the first tie
    end else begin
      for (int n = 0; n < 4; n++) begin
        st_q[n]    <= st_d[n];
        cmd_q[n]   <= cmd_d[n];
        op1_q[n]   <= op1_d[n];
        op2_q[n]   <= op2_d[n];
        resp_q[n]  <= resp_d[n];
        rdata_q[n] <= rdata_d[n];
      end
      alu_busy_q <= alu_busy_d;
      alu_cnt_q  <= alu_cnt_d;
      alu_port_q <= alu_port_d;
      rr_q       <= rr_d;
    end
  end

`ifdef CALC1_PROTO_CHECK_EN
  logic [3:0] perr_q, perr_d;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      perr_d[n] = perr_q[n] | ((st_q[n] != StIdle) && (cmd_in[n] != 4'd0));
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      perr_q <= '0;
    end else begin
      perr_q <= perr_d;
      for (int n = 0; n < 4; n++) begin
        if (perr_d[n] && !perr_q[n]) begin
          $display("calc1_responder: protocol error on port %0d at time %0t", n + 1, $time);
        end
      end
    end
  end

  assign proto_err = {perr_q[0], perr_q[1], perr_q[2], perr_q[3]};
`endif

endmodule

// File: doc/calc1_responder.md
Name: calc1_responder

Overview:
- Behavioural responder for the calc1 request/response interface: the far end of the calc1 driver.
- Four independent request ports each accept a two-cycle request:
  - cycle 1: command + operand 1;
  - cycle 2: NOP + operand 2.
- Pending requests are arbitrated round-robin onto one shared, non-pipelined ALU.
- Each port receives a one-cycle response (code + data).
- Used as a reference/stand-in calculator so driver and checker benches run without the real DUT.

Parameters:
- ALU_LAT, 2, cycles from ALU grant to registered response; legal range 1..15.

Ports:
- c_clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- reqN_cmd_in  input  [0:3]  command for port N (N=1..4); 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH
- reqN_data_in  input  [0:31]  operand for port N (N=1..4); bit 0 is MSB
- out_respN  output  [0:1]  response code for port N (N=1..4); 0 none, 1 success, 2 overflow/underflow, 3 invalid command
- out_dataN  output  [0:31]  result for port N (N=1..4); valid only while out_respN != 0
- proto_err  output  [1:4]  sticky per-port protocol error; present only with CALC1_PROTO_CHECK_EN

Behaviour:
- Reset, sampled at a c_clk edge with reset=1:
  - all out_respN=0, out_dataN=0, proto_err=0;
  - all ports IDLE, ALU idle, RR pointer=4 so port 1 wins the first tie.
  - Asserting reset mid-operation discards all captured and in-flight requests; no response is ever emitted for them.
- Per-port FSM, states IDLE -> OP2 -> WAIT -> EXEC -> IDLE:
  - IDLE: cmd != 0 at edge E0 latches cmd and op1, go OP2. cmd = 0 means stay.
  - OP2: at E1 latch data as op2, go WAIT. The cmd value is ignored.
  - WAIT: stay until granted; on grant go EXEC.
  - EXEC: at the edge the response register is written, go IDLE.
  - A non-NOP cmd sampled in OP2/WAIT/EXEC, including the response edge itself, is ignored.
  - The next request is accepted from the edge after the response cycle.
- Arbiter / ALU:
  - Grant evaluated at each edge when the ALU is free.
  - The ALU is also free at the edge where it writes a response, so back-to-back issue is allowed.
  - Candidates are WAIT ports only; search starts at RR pointer+1 (4 wraps to 1). The pointer updates to the granted port.
  - Earliest grant is E2. The response register is written at grant edge + ALU_LAT.
  - out_respN/out_dataN are held for exactly one cycle, then return to 0.
  - Uncontended latency with ALU_LAT=2: response visible in the cycle after E4.
  - One grant per ALU_LAT cycles maximum.
- Arithmetic (unsigned 32-bit):
  - ADD: 33-bit sum. Carry out gives resp 2, data 0; else resp 1, data = sum.
  - SUB: op1 < op2 gives resp 2, data 0; else resp 1, data = op1 - op2. Equal operands give resp 1, data 0.
  - LSH: op1 << op2[27:31] (low 5 bits only), zero fill, resp 1. Shifted-out bits never flag overflow.
  - RSH: op1 >> op2[27:31], logical, resp 1.
  - Any other nonzero cmd (3, 4, 7..15): resp 3, data 0. It still consumes op2 and an ALU slot.
- Only the granted port's outputs change; all other ports' outputs stay 0.

Optional Feature:
- Macro: CALC1_PROTO_CHECK_EN.
- Defined:
  - adds the proto_err port;
  - a non-NOP cmd sampled while the port is in OP2/WAIT/EXEC sets proto_err[N] until reset;
  - issues one $display with port number and simulation time.
- Undefined: no proto_err port and no checking logic. Such commands are silently ignored as described in Behaviour.

Test Plan:
- Port1 ADD 0xFFFF0000 then op2 0x0000FFFF -> out_resp1=1, out_data1=0xFFFFFFFF in the cycle after E4, for one cycle only; then 0.
- Port2 ADD 0xFFFFFFFF + 1 -> resp 2, data 0.
- Port2 SUB 1 - 100 -> resp 2, data 0.
- Port2 SUB 100 - 1 -> resp 1, data 99.
- Port3 LSH 0x00000001 by 31 -> resp 1, data 0x80000000.
- Port3 RSH 0x80000000 by 0x24 (low 5 bits = 4) -> data 0x08000000.
- Just after reset, simultaneous port3 ADD 1+4 and port4 ADD 2+8:
  - port3 responds first with 5;
  - port4 responds with 10 exactly ALU_LAT cycles later.
  - Then a 4-port tie after a port1 grant -> grant order 2, 3, 4, 1.
- Port4 cmd 4 with op2 7 -> resp 3, data 0.
- Port1 ADD with reset asserted during EXEC -> no response; all outputs 0.
  - The next ADD 2+2 after reset is released -> resp 1, data 4.
  - With CALC1_PROTO_CHECK_EN, a port1 ADD sent during the OP2 cycle -> proto_err[1]=1; the original request still completes correctly.
